// File: rtl/safecrack_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | safecrack_pkg: shared types/constants for the safecrack frontend |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package safecrack_pkg;

  localparam logic [3:0] BTN_IDLE = 4'b1111;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    WAIT_REL = 1'b1
  } fe_state_t;

  // True when exactly one of the active-low bits is pressed.
  function automatic logic onehot_low(input logic [3:0] v);
    logic [2:0] zeros;
    zeros = '0;
    for (int i = 0; i < 4; i++) begin
      zeros = zeros + {2'b00, ~v[i]};
    end
    return (zeros == 3'd1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/safecrack_debounce.sv
`default_nettype none
// +------------------------------------------------------------------+
// | safecrack_debounce: 2-flop synchronizer + stability counter      |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module safecrack_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  localparam int c_cnt_w = $clog2(DEBOUNCE_CYCLES);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);

  logic               r_sync1;
  logic               r_sync2;
  logic               r_db;
  logic [c_cnt_w-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_db    <= 1'b1;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= din;
      r_sync2 <= r_sync1;
      // Any sample agreeing with the accepted level restarts the count.
      if (r_sync2 != r_db) begin
        if (r_cnt == c_cnt_last) begin
          r_db  <= r_sync2;
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign dout = r_db;

endmodule
`default_nettype wire

// File: rtl/safecrack_btn_frontend.sv
`default_nettype none
// +------------------------------------------------------------------+
// | safecrack_btn_frontend: debounced press codes, ms pulse, 1s tick |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module safecrack_btn_frontend
  import safecrack_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int TICK_CYCLES     = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn_raw,
  input  logic       ms_raw,
  input  logic       tick_clr,
  output logic [3:0] btn_out,
  output logic       btn_valid,
  output logic       ms_pulse,
  output logic       multi_err,
  output logic       sec_tick
);

  localparam int c_tick_w = $clog2(TICK_CYCLES);
  localparam logic [c_tick_w-1:0] c_tick_last = c_tick_w'(TICK_CYCLES - 1);

  logic [3:0] w_btn_db;
  logic       w_ms_db;

  generate
    for (genvar i = 0; i < 4; i++) begin : g_btn
      safecrack_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_db (
        .clk (clk),
        .rst (rst),
        .din (btn_raw[i]),
        .dout(w_btn_db[i])
      );
    end
  endgenerate

  safecrack_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_ms (
    .clk (clk),
    .rst (rst),
    .din (ms_raw),
    .dout(w_ms_db)
  );

  fe_state_t  r_state;
  fe_state_t  w_state_nxt;
  logic [3:0] r_btn_out;
  logic [3:0] w_btn_out_nxt;
  logic       r_valid;
  logic       w_valid_nxt;
  logic       r_merr;
  logic       w_merr_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_btn_out <= BTN_IDLE;
      r_valid   <= 1'b0;
      r_merr    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_btn_out <= w_btn_out_nxt;
      r_valid   <= w_valid_nxt;
      r_merr    <= w_merr_nxt;
    end
  end

  // A press is reported once; everything else waits for a full release.
  always_comb begin
    w_state_nxt   = r_state;
    w_btn_out_nxt = BTN_IDLE;
    w_valid_nxt   = 1'b0;
    w_merr_nxt    = 1'b0;
    case (r_state)
      IDLE: begin
        if (onehot_low(w_btn_db)) begin
          w_valid_nxt   = 1'b1;
          w_btn_out_nxt = w_btn_db;
          w_state_nxt   = WAIT_REL;
        end else if (w_btn_db != BTN_IDLE) begin
          w_merr_nxt  = 1'b1;
          w_state_nxt = WAIT_REL;
        end
      end
      WAIT_REL: begin
        if (w_btn_db == BTN_IDLE) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  logic r_ms_prev;
  logic r_ms_pulse;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ms_prev  <= 1'b1;
      r_ms_pulse <= 1'b0;
    end else begin
      r_ms_prev  <= w_ms_db;
      r_ms_pulse <= r_ms_prev & ~w_ms_db;
    end
  end

  logic [c_tick_w-1:0] r_tick_cnt;
  logic                r_sec_tick;

  always_ff @(posedge clk) begin
    if (rst || tick_clr) begin
      r_tick_cnt <= '0;
      r_sec_tick <= 1'b0;
    end else if (r_tick_cnt == c_tick_last) begin
      r_tick_cnt <= '0;
      r_sec_tick <= 1'b1;
    end else begin
      r_tick_cnt <= r_tick_cnt + 1'b1;
      r_sec_tick <= 1'b0;
    end
  end

  assign btn_out   = r_btn_out;
  assign btn_valid = r_valid;
  assign multi_err = r_merr;
  assign ms_pulse  = r_ms_pulse;
  assign sec_tick  = r_sec_tick;

endmodule
`default_nettype wire

// File: tb/tb_safecrack_btn_frontend.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_safecrack_btn_frontend: directed checks, DEBOUNCE=4, TICK=10  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_safecrack_btn_frontend;

  logic       clk;
  logic       rst;
  logic [3:0] btn_raw;
  logic       ms_raw;
  logic       tick_clr;
  logic [3:0] btn_out;
  logic       btn_valid;
  logic       ms_pulse;
  logic       multi_err;
  logic       sec_tick;

  int checks;
  int errors;
  int m_cnt;
  logic m_tick;

  safecrack_btn_frontend #(
    .DEBOUNCE_CYCLES(4),
    .TICK_CYCLES    (10)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_raw  (btn_raw),
    .ms_raw   (ms_raw),
    .tick_clr (tick_clr),
    .btn_out  (btn_out),
    .btn_valid(btn_valid),
    .ms_pulse (ms_pulse),
    .multi_err(multi_err),
    .sec_tick (sec_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
    end
  endtask

  // One clock; the seconds tick follows its own reference count.
  task automatic step(input logic [3:0] e_out, input logic e_v, input logic e_m,
                      input logic e_ms);
    @(posedge clk);
    if (rst || tick_clr) begin
      m_cnt  = 0;
      m_tick = 1'b0;
    end else if (m_cnt == 9) begin
      m_cnt  = 0;
      m_tick = 1'b1;
    end else begin
      m_cnt  = m_cnt + 1;
      m_tick = 1'b0;
    end
    #1;
    chk("btn_out", btn_out, e_out);
    chk("btn_valid", {3'b000, btn_valid}, {3'b000, e_v});
    chk("multi_err", {3'b000, multi_err}, {3'b000, e_m});
    chk("ms_pulse", {3'b000, ms_pulse}, {3'b000, e_ms});
    chk("sec_tick", {3'b000, sec_tick}, {3'b000, m_tick});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(4'b1111, 1'b0, 1'b0, 1'b0);
  endtask

  // Raw press stable before edge 1 gives the strobe after edge 7.
  task automatic press(input logic [3:0] code);
    btn_raw = code;
    idle(6);
    step(code, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    m_cnt    = 0;
    m_tick   = 1'b0;
    rst      = 1'b1;
    btn_raw  = 4'b1111;
    ms_raw   = 1'b1;
    tick_clr = 1'b0;

    // Reset and idle, ticks at 10/20/30/40
    idle(2);
    rst = 1'b0;
    idle(40);

    // Single press held 50 cycles, release, second button
    press(4'b1110);
    idle(43);
    btn_raw = 4'b1111;
    idle(20);
    press(4'b1101);
    idle(10);
    btn_raw = 4'b1111;
    idle(20);

    // Bouncing button 1, then held low
    for (int k = 0; k < 5; k++) begin
      btn_raw = 4'b1101;
      idle(2);
      btn_raw = 4'b1111;
      idle(2);
    end
    press(4'b1101);
    btn_raw = 4'b1111;
    idle(20);

    // Chord rejection, then a clean press
    btn_raw = 4'b1100;
    idle(6);
    step(4'b1111, 1'b0, 1'b1, 1'b0);
    idle(20);
    btn_raw = 4'b1111;
    idle(20);
    press(4'b1011);
    btn_raw = 4'b1111;
    idle(20);

    // Second button while first held is ignored
    press(4'b1110);
    idle(3);
    btn_raw = 4'b1100;
    idle(20);
    btn_raw = 4'b1101;
    idle(20);
    btn_raw = 4'b1111;
    idle(20);
    press(4'b0111);
    btn_raw = 4'b1111;
    idle(20);

    // Change-password button: one pulse, no repeat while held
    ms_raw = 1'b0;
    idle(6);
    step(4'b1111, 1'b0, 1'b0, 1'b1);
    idle(20);
    ms_raw = 1'b1;
    idle(20);

    // Reset mid-debounce with button held: full latency restarts
    btn_raw = 4'b1110;
    idle(4);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    press(4'b1110);
    btn_raw = 4'b1111;
    idle(20);

    // Tick phase restart at count 5
    for (int k = 0; k < 10 && m_cnt != 5; k++) idle(1);
    chk("tick_phase_found", m_cnt[3:0], 4'd5);
    tick_clr = 1'b1;
    idle(1);
    tick_clr = 1'b0;
    idle(9);
    chk("tick_not_early", {3'b000, sec_tick}, 4'd0);
    idle(1);
    chk("tick_after_clr", {3'b000, sec_tick}, 4'd1);
    idle(12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
